// File: rtl/img2col_ctrl_if.sv
// img2col_ctrl_if -- bundles the layer configuration, the address-generator
// handshakes, the tile handshake to the GEMM and all derived geometry outputs
// of img2col_ctrl.
//   slave  : controller side (config/handshake in, geometry/status out)
//   master : environment side (drives config/handshake, observes outputs)
interface img2col_ctrl_if #(
  parameter int TS_W   = 8,
  parameter int KS_W   = 4,
  parameter int CH_W   = 8,
  parameter int ST_W   = 2,
  parameter int KN_W   = 8,
  parameter int S2P    = 4,
  parameter int ADDR_W = 16
);
  localparam int LG = $clog2(S2P);
  localparam int WW = 2*KS_W + CH_W;

  logic                 start;
  logic [TS_W-1:0]      tensor_size;
  logic [KS_W-1:0]      kernel_size;
  logic [CH_W-1:0]      channels;
  logic [ST_W-1:0]      stride;
  logic [KN_W-1:0]      kernel_nums;
  logic                 tensor_done;
  logic                 weight_done;
  logic                 flag_buffer;
  logic                 tile_ready;

  logic                 enable;
  logic [TS_W+ST_W-1:0] t_mul_s;
  logic [TS_W-1:0]      out_feature_size;
  logic [LG-1:0]        img2col_t_length_rem;
  logic [WW-1:0]        buffer_row_nums_t;
  logic [ADDR_W-1:0]    switch_row_add_nums;
  logic [ADDR_W-1:0]    switch_channel_add_nums;
  logic [WW-1:0]        img2col_w_width;
  logic [LG-1:0]        img2col_w_width_rem;
  logic [WW-1:0]        buffer_col_nums;
  logic [KN_W-1:0]      buffer_row_nums_w;
  logic [LG-1:0]        kernel_nums_rem;
  logic                 tile_valid;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport slave (
    input  start, tensor_size, kernel_size, channels, stride, kernel_nums,
           tensor_done, weight_done, flag_buffer, tile_ready,
    output enable, t_mul_s, out_feature_size, img2col_t_length_rem,
           buffer_row_nums_t, switch_row_add_nums, switch_channel_add_nums,
           img2col_w_width, img2col_w_width_rem, buffer_col_nums,
           buffer_row_nums_w, kernel_nums_rem, tile_valid, busy, done, err
  );

  modport master (
    output start, tensor_size, kernel_size, channels, stride, kernel_nums,
           tensor_done, weight_done, flag_buffer, tile_ready,
    input  enable, t_mul_s, out_feature_size, img2col_t_length_rem,
           buffer_row_nums_t, switch_row_add_nums, switch_channel_add_nums,
           img2col_w_width, img2col_w_width_rem, buffer_col_nums,
           buffer_row_nums_w, kernel_nums_rem, tile_valid, busy, done, err
  );
endinterface

// File: rtl/img2col_ctrl.sv
// img2col_ctrl -- layer controller for the img2col/GEMM datapath.
// Latches a layer configuration on start, validates it, derives the output
// feature edge by repeated subtraction (no divider), registers all derived
// tiling geometry, then runs the img2col engine while tracking the tile
// handshake to the GEMM until both address generators report completion.
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset
//   bus  - img2col_ctrl_if.slave (config, handshakes, geometry, status)
module img2col_ctrl #(
  parameter int TS_W   = 8,
  parameter int KS_W   = 4,
  parameter int CH_W   = 8,
  parameter int ST_W   = 2,
  parameter int KN_W   = 8,
  parameter int S2P    = 4,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           rstn,
  img2col_ctrl_if.slave  bus
);
  localparam int LG   = $clog2(S2P);
  localparam int WW   = 2*KS_W + CH_W;
  localparam int SQ_W = 2*TS_W;
  localparam int TM_W = TS_W + ST_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CALC  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [KS_W-1:0] ks;
    logic [CH_W-1:0] ch;
    logic [ST_W-1:0] st;
    logic [KN_W-1:0] kn;
  } cfg_t;

  typedef struct packed {
    logic [TM_W-1:0]   t_mul_s;
    logic [TS_W-1:0]   ofs;
    logic [LG-1:0]     t_len_rem;
    logic [WW-1:0]     row_t;
    logic [ADDR_W-1:0] sw_row;
    logic [ADDR_W-1:0] sw_ch;
    logic [WW-1:0]     w_width;
    logic [LG-1:0]     w_rem;
    logic [WW-1:0]     col;
    logic [KN_W-1:0]   row_w;
    logic [LG-1:0]     kn_rem;
  } drv_t;

  state_e          state_q, state_d;
  cfg_t            cfg_q, cfg_d;
  drv_t            drv_q, drv_d, drv_calc_s;
  logic [TS_W-1:0] r_q, r_d, q_q, q_d;
  logic            err_q, err_d;
  logic            tv_q, tv_d;
  logic            flag_q;
  logic            td_seen_q, td_seen_d, wd_seen_q, wd_seen_d;

  logic            flag_edge_s, cfg_bad_s;
  logic [TS_W-1:0] st_ext_s, ofs_s;
  logic [SQ_W-1:0] ofs_x_s, osq_s, ts_x_s, tsq_s;
  logic [WW-1:0]   ww_s;

  // Either polarity of flag_buffer marks one completed tile pair.
  assign flag_edge_s = bus.flag_buffer ^ flag_q;
  assign st_ext_s    = TS_W'(cfg_q.st);
  assign cfg_bad_s   = (cfg_q.st == '0) || (cfg_q.ks == '0) || (cfg_q.ch == '0) ||
                       (cfg_q.kn == '0) || (TS_W'(cfg_q.ks) > cfg_q.ts);

  // Derived geometry from the finished quotient; mod/ceil by S2P use low bits and shifts.
  always_comb begin
    ofs_s   = q_q + TS_W'(1'b1);
    ofs_x_s = SQ_W'(ofs_s);
    osq_s   = ofs_x_s * ofs_x_s;
    ts_x_s  = SQ_W'(cfg_q.ts);
    tsq_s   = ts_x_s * ts_x_s;
    ww_s    = WW'(cfg_q.ks) * WW'(cfg_q.ks) * WW'(cfg_q.ch);
    drv_calc_s.t_mul_s   = TM_W'(cfg_q.ts) * TM_W'(cfg_q.st);
    drv_calc_s.ofs       = ofs_s;
    drv_calc_s.t_len_rem = osq_s[LG-1:0];
    drv_calc_s.row_t     = WW'(osq_s >> LG) + WW'(|osq_s[LG-1:0]);
    drv_calc_s.sw_row    = ADDR_W'(cfg_q.ts - TS_W'(cfg_q.ks));
    drv_calc_s.sw_ch     = ADDR_W'(tsq_s);
    drv_calc_s.w_width   = ww_s;
    drv_calc_s.w_rem     = ww_s[LG-1:0];
    drv_calc_s.col       = (ww_s >> LG) + WW'(|ww_s[LG-1:0]);
    drv_calc_s.row_w     = (cfg_q.kn >> LG) + KN_W'(|cfg_q.kn[LG-1:0]);
    drv_calc_s.kn_rem    = cfg_q.kn[LG-1:0];
  end

  // Next-state, tile handshake tracking and datapath register updates.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    drv_d     = drv_q;
    r_d       = r_q;
    q_d       = q_q;
    err_d     = err_q;
    tv_d      = tv_q;
    td_seen_d = td_seen_q;
    wd_seen_d = wd_seen_q;

    if (state_q != S_IDLE) begin
      td_seen_d = td_seen_q | bus.tensor_done;
      wd_seen_d = wd_seen_q | bus.weight_done;
    end else begin
      td_seen_d = td_seen_q;
      wd_seen_d = wd_seen_q;
    end

    // A new tile wins over a same-cycle accept; a new tile over a stalled one is an overrun.
    if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      if (flag_edge_s) begin
        tv_d = 1'b1;
        if (tv_q && !bus.tile_ready) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end else if (tv_q && bus.tile_ready) begin
        tv_d = 1'b0;
      end else begin
        tv_d = tv_q;
      end
    end else begin
      tv_d = tv_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cfg_d     = '{ts: bus.tensor_size, ks: bus.kernel_size, ch: bus.channels,
                        st: bus.stride, kn: bus.kernel_nums};
          drv_d     = '0;
          err_d     = 1'b0;
          tv_d      = 1'b0;
          td_seen_d = 1'b0;
          wd_seen_d = 1'b0;
          state_d   = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (cfg_bad_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          r_d     = cfg_q.ts - TS_W'(cfg_q.ks);
          q_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (r_q >= st_ext_s) begin
          r_d = r_q - st_ext_s;
          q_d = q_q + TS_W'(1'b1);
        end else begin
          drv_d   = drv_calc_s;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if ((td_seen_q | bus.tensor_done) && (wd_seen_q | bus.weight_done)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!tv_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      drv_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      err_q     <= 1'b0;
      tv_q      <= 1'b0;
      flag_q    <= 1'b0;
      td_seen_q <= 1'b0;
      wd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      drv_q     <= drv_d;
      r_q       <= r_d;
      q_q       <= q_d;
      err_q     <= err_d;
      tv_q      <= tv_d;
      flag_q    <= bus.flag_buffer;
      td_seen_q <= td_seen_d;
      wd_seen_q <= wd_seen_d;
    end
  end

  // Enable follows the stall condition combinationally so a ready tile releases it at once.
  assign bus.enable                  = (state_q == S_RUN) && !(tv_q && !bus.tile_ready);
  assign bus.busy                    = (state_q != S_IDLE);
  assign bus.done                    = (state_q == S_DONE);
  assign bus.err                     = err_q;
  assign bus.tile_valid              = tv_q;
  assign bus.t_mul_s                 = drv_q.t_mul_s;
  assign bus.out_feature_size        = drv_q.ofs;
  assign bus.img2col_t_length_rem    = drv_q.t_len_rem;
  assign bus.buffer_row_nums_t       = drv_q.row_t;
  assign bus.switch_row_add_nums     = drv_q.sw_row;
  assign bus.switch_channel_add_nums = drv_q.sw_ch;
  assign bus.img2col_w_width         = drv_q.w_width;
  assign bus.img2col_w_width_rem     = drv_q.w_rem;
  assign bus.buffer_col_nums         = drv_q.col;
  assign bus.buffer_row_nums_w       = drv_q.row_w;
  assign bus.kernel_nums_rem         = drv_q.kn_rem;
endmodule

// File: tb/tb_img2col_ctrl.sv
// tb_img2col_ctrl -- directed self-checking bench for img2col_ctrl.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_img2col_ctrl;
  localparam int TS_W   = 8;
  localparam int KS_W   = 4;
  localparam int CH_W   = 8;
  localparam int ST_W   = 2;
  localparam int KN_W   = 8;
  localparam int S2P    = 4;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wait;

  always #5 clk = ~clk;

  img2col_ctrl_if #(.TS_W(TS_W), .KS_W(KS_W), .CH_W(CH_W), .ST_W(ST_W),
                    .KN_W(KN_W), .S2P(S2P), .ADDR_W(ADDR_W)) bus ();

  img2col_ctrl #(.TS_W(TS_W), .KS_W(KS_W), .CH_W(CH_W), .ST_W(ST_W),
                 .KN_W(KN_W), .S2P(S2P), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int ts, input int ks, input int ch, input int st, input int kn);
    bus.tensor_size = TS_W'(ts);
    bus.kernel_size = KS_W'(ks);
    bus.channels    = CH_W'(ch);
    bus.stride      = ST_W'(st);
    bus.kernel_nums = KN_W'(kn);
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  // Ticks until enable rises, bounded; returns the number of ticks taken.
  task automatic wait_enable(output int n);
    n = 0;
    while ((bus.enable !== 1'b1) && (n < 50)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn            = 1'b0;
    bus.start       = 1'b0;
    bus.tensor_size = '0;
    bus.kernel_size = '0;
    bus.channels    = '0;
    bus.stride      = '0;
    bus.kernel_nums = '0;
    bus.tensor_done = 1'b0;
    bus.weight_done = 1'b0;
    bus.flag_buffer = 1'b0;
    bus.tile_ready  = 1'b0;
    tick();
    tick();
    chk("rst_enable", bus.enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ofs", bus.out_feature_size, 0);
    rstn = 1'b1;
    tick();

    // Layer 1: tensor 5, kernel 3, stride 1, channels 2, kernel_nums 5.
    start_layer(5, 3, 2, 1, 5);
    chk("l1_busy", bus.busy, 1);
    chk("l1_en_check", bus.enable, 0);
    wait_enable(n_wait);
    chk("l1_calc_len", n_wait - 1, 3);
    chk("l1_ofs", bus.out_feature_size, 3);
    chk("l1_tms", bus.t_mul_s, 5);
    chk("l1_wwidth", bus.img2col_w_width, 18);
    chk("l1_wrem", bus.img2col_w_width_rem, 2);
    chk("l1_cols", bus.buffer_col_nums, 5);
    chk("l1_rows_w", bus.buffer_row_nums_w, 2);
    chk("l1_kn_rem", bus.kernel_nums_rem, 1);
    chk("l1_rows_t", bus.buffer_row_nums_t, 3);
    chk("l1_t_rem", bus.img2col_t_length_rem, 1);
    chk("l1_sw_row", bus.switch_row_add_nums, 2);
    chk("l1_sw_ch", bus.switch_channel_add_nums, 25);

    // Tile stall, overrun, release.
    bus.flag_buffer = 1'b1;
    tick();
    chk("stall_tv", bus.tile_valid, 1);
    chk("stall_en", bus.enable, 0);
    chk("stall_err", bus.err, 0);
    bus.flag_buffer = 1'b0;
    tick();
    chk("ovr_err", bus.err, 1);
    chk("ovr_tv", bus.tile_valid, 1);
    bus.tile_ready = 1'b1;
    tick();
    chk("acc_tv", bus.tile_valid, 0);
    chk("acc_en", bus.enable, 1);
    bus.flag_buffer = 1'b1;
    tick();
    chk("rdy_tv", bus.tile_valid, 1);
    chk("rdy_en", bus.enable, 1);
    bus.flag_buffer = 1'b0;
    tick();
    chk("simul_tv", bus.tile_valid, 1);
    chk("simul_err_sticky", bus.err, 1);
    tick();
    chk("simul_clr_tv", bus.tile_valid, 0);

    // weight_done four cycles ahead of tensor_done.
    bus.weight_done = 1'b1;
    tick();
    bus.weight_done = 1'b0;
    tick();
    tick();
    tick();
    chk("wd_still_run", bus.enable, 1);
    bus.tensor_done = 1'b1;
    tick();
    bus.tensor_done = 1'b0;
    chk("drain_en", bus.enable, 0);
    chk("drain_busy", bus.busy, 1);
    chk("drain_done", bus.done, 0);
    tick();
    chk("l1_done", bus.done, 1);
    tick();
    chk("l1_done_end", bus.done, 0);
    chk("l1_idle", bus.busy, 0);
    chk("l1_hold_ofs", bus.out_feature_size, 3);
    chk("l1_hold_ww", bus.img2col_w_width, 18);

    // Layer 2: kernel larger than tensor.
    bus.tile_ready = 1'b0;
    start_layer(5, 6, 2, 1, 5);
    chk("l2_err_clr", bus.err, 0);
    chk("l2_en0", bus.enable, 0);
    chk("l2_done0", bus.done, 0);
    tick();
    chk("l2_done", bus.done, 1);
    chk("l2_err", bus.err, 1);
    chk("l2_en1", bus.enable, 0);
    tick();
    chk("l2_done_end", bus.done, 0);
    chk("l2_idle", bus.busy, 0);
    chk("l2_err_sticky", bus.err, 1);
    chk("l2_ofs", bus.out_feature_size, 0);

    // Layer 3: tensor 7, kernel 3, stride 2, channels 1, kernel_nums 4; reset mid-run.
    start_layer(7, 3, 1, 2, 4);
    wait_enable(n_wait);
    chk("l3_calc_len", n_wait - 1, 3);
    chk("l3_ofs", bus.out_feature_size, 3);
    chk("l3_tms", bus.t_mul_s, 14);
    chk("l3_wwidth", bus.img2col_w_width, 9);
    chk("l3_cols", bus.buffer_col_nums, 3);
    chk("l3_rows_w", bus.buffer_row_nums_w, 1);
    chk("l3_kn_rem", bus.kernel_nums_rem, 0);
    chk("l3_sw_row", bus.switch_row_add_nums, 4);
    chk("l3_sw_ch", bus.switch_channel_add_nums, 49);
    bus.flag_buffer = 1'b1;
    tick();
    chk("l3_tv", bus.tile_valid, 1);
    rstn = 1'b0;
    tick();
    chk("mrst_en", bus.enable, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_tv", bus.tile_valid, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_ofs", bus.out_feature_size, 0);
    chk("mrst_tms", bus.t_mul_s, 0);
    chk("mrst_cols", bus.buffer_col_nums, 0);
    rstn = 1'b1;
    tick();
    chk("mrst_no_done", bus.done, 0);

    // Fresh start after reset completes normally.
    start_layer(7, 3, 1, 2, 4);
    wait_enable(n_wait);
    chk("l4_calc_len", n_wait - 1, 3);
    chk("l4_ofs", bus.out_feature_size, 3);
    chk("l4_tv", bus.tile_valid, 0);
    bus.tensor_done = 1'b1;
    bus.weight_done = 1'b1;
    tick();
    bus.tensor_done = 1'b0;
    bus.weight_done = 1'b0;
    chk("l4_drain_en", bus.enable, 0);
    tick();
    chk("l4_done", bus.done, 1);
    chk("l4_err", bus.err, 0);
    tick();
    chk("l4_done_end", bus.done, 0);
    chk("l4_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/img2col_ctrl.md
IMG2COL_CTRL -- requirements
Module: img2col_ctrl

Interface
REQ-001 SHALL have parameters: TS_W, 8, tensor-size width; KS_W, 4, kernel-size width; CH_W, 8, channel-count width; ST_W, 2, stride width; KN_W, 8, kernel-count width; S2P, 4, tile edge (power of 2); ADDR_W, 16, address width.
REQ-002 SHALL use one clock, clk; reset rstn is synchronous and active-low.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rstn  in  1  sync active-low reset
- start  in  1  layer start pulse
- tensor_size  in  TS_W  input feature edge
- kernel_size  in  KS_W  kernel edge
- channels  in  CH_W  input channels
- stride  in  ST_W  conv stride
- kernel_nums  in  KN_W  kernel count
- tensor_done  in  1  from address generator
- weight_done  in  1  from address generator
- flag_buffer  in  1  toggles once per completed tile pair
- tile_ready  in  1  downstream GEMM accepts tile
- enable  out  1  img2col run enable
- t_mul_s  out  TS_W+ST_W  tensor_size*stride
- out_feature_size  out  TS_W  output edge
- img2col_t_length_rem  out  log2(S2P)  out_feature_size^2 mod S2P
- buffer_row_nums_t  out  2*KS_W+CH_W  ceil(out_feature_size^2/S2P)
- switch_row_add_nums  out  ADDR_W  tensor_size-kernel_size
- switch_channel_add_nums  out  ADDR_W  tensor_size*tensor_size
- img2col_w_width  out  2*KS_W+CH_W  kernel_size^2*channels
- img2col_w_width_rem  out  log2(S2P)  img2col_w_width mod S2P
- buffer_col_nums  out  2*KS_W+CH_W  ceil(img2col_w_width/S2P)
- buffer_row_nums_w  out  KN_W  ceil(kernel_nums/S2P)
- kernel_nums_rem  out  log2(S2P)  kernel_nums mod S2P
- tile_valid  out  1  tile available to GEMM
- busy  out  1  state != IDLE
- done  out  1  one-cycle layer-complete pulse
- err  out  1  config error, sticky until next start

Function
REQ-004 SHALL implement FSM IDLE -> CHECK -> CALC -> RUN -> DRAIN -> DONE -> IDLE.
REQ-005 IDLE: start=1 latches all config inputs, clears err and tile counters, moves to CHECK; start ignored in any other state.
REQ-006 CHECK (1 cycle): stride==0, kernel_size==0, channels==0, kernel_nums==0 or kernel_size>tensor_size SHALL set err=1 and go to DONE without enable; otherwise go to CALC.
REQ-007 CALC SHALL compute out_feature_size by repeated subtraction: r=tensor_size-kernel_size, q=0; each cycle while r>=stride: r-=stride, q+=1; when r<stride, out_feature_size=q+1, all derived outputs registered, next state RUN; duration floor(r0/stride)+1 cycles.
REQ-008 Derived outputs SHALL be computed at full width without truncation; mod/ceil by S2P SHALL use low log2(S2P) bits and right shift.
REQ-009 Derived outputs SHALL hold stable from end of CALC until next start.
REQ-010 RUN: enable = !stall, where stall = tile_valid && !tile_ready.
REQ-011 Each flag_buffer edge (either polarity, detected against a 1-cycle delayed copy) SHALL set tile_valid; tile_valid clears on the cycle tile_valid && tile_ready; simultaneous edge and accept keeps tile_valid=1.
REQ-012 A flag_buffer edge while tile_valid=1 and tile_ready=0 SHALL set err=1 (overrun); operation continues.
REQ-013 RUN -> DRAIN when tensor_done and weight_done have both been seen (each latched sticky, same-cycle or separate).
REQ-014 DRAIN: enable=0; wait until tile_valid=0, then DONE.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE.
REQ-016 enable SHALL be 0 in all states except RUN.

Reset
REQ-017 rstn=0 at a clk edge SHALL force IDLE; enable, tile_valid, busy, done, err, all derived outputs and internal counters/latches to 0, regardless of state.
REQ-018 Reset mid-RUN SHALL drop enable on the same edge; no done pulse is produced.

Verification
REQ-019 tensor 5, kernel 3, stride 1, channels 2, kernel_nums 5, S2P 4 -> out_feature_size 3, t_mul_s 5, w_width 18, w_width_rem 2, col_nums 5, row_nums_w 2, kn_rem 1, row_nums_t 3, t_length_rem 1, switch_row 2, switch_channel 25; CALC lasts 3 cycles.
REQ-020 tensor 7, kernel 3, stride 2 -> out_feature_size 3, t_mul_s 14; CALC lasts 3 cycles.
REQ-021 kernel 6 > tensor 5 -> err=1, enable never 1, done pulse 2 cycles after start.
REQ-022 RUN with tile_ready=0 after flag_buffer toggle -> enable=0 next cycle; tile_ready=1 -> tile_valid clears, enable returns 1; second toggle while pending -> err=1.
REQ-023 weight_done 4 cycles before tensor_done -> DRAIN entered the cycle after tensor_done; one done pulse.
REQ-024 rstn=0 during RUN -> next cycle enable=0, busy=0, all outputs 0; fresh start then completes normally.
